// File: rtl/cpuif_ack_watchdog_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpuif_wdog_pkg
// Brief    : Shared types and constants for the CPU-interface ack watchdog.
// Revision : 1.0 - initial release
// ============================================================================
package cpuif_wdog_pkg;

    localparam int TIMEOUT_CNT_W      = 8;
    localparam int c_cpuif_min_addr_w = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERR_RESP = 2'd2,
        DRAIN    = 2'd3
    } cpuif_wdog_state_e;

    // Picks the write- or read-side flavour of a per-direction strobe.
    function automatic logic dir_sel(input logic is_wr, input logic wr_val, input logic rd_val);
        return is_wr ? wr_val : rd_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpuif_ack_watchdog_if.sv
`default_nettype none
// ============================================================================
// Interface : cpuif_ack_watchdog_if
// Brief     : CSR access port bundle (request fields, stalls, acks, read data).
// Revision  : 1.0 - initial release
// ============================================================================
interface cpuif_ack_watchdog_if
    import cpuif_wdog_pkg::*;
#(
    parameter int ADDR_WIDTH = c_cpuif_min_addr_w,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  req_is_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_biten;
    logic                  req_stall_wr;
    logic                  req_stall_rd;
    logic                  rd_ack;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_ack;
    logic                  wr_err;

    // Requester side: issues requests, receives stalls and responses.
    modport master (
        output req, req_is_wr, addr, wr_data, wr_biten,
        input  req_stall_wr, req_stall_rd, rd_ack, rd_err, rd_data, wr_ack, wr_err
    );

    // Responder side: receives requests, returns stalls and responses.
    modport slave (
        input  req, req_is_wr, addr, wr_data, wr_biten,
        output req_stall_wr, req_stall_rd, rd_ack, rd_err, rd_data, wr_ack, wr_err
    );

endinterface
`default_nettype wire

// File: rtl/cpuif_ack_watchdog_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; clear beats restart beats inc.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_restart,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= WIDTH'(1);
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/cpuif_ack_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : cpuif_ack_watchdog
// Brief    : Zero-latency CSR port pass-through that converts a missing or
//            stalled ack into a single error ack and counts the timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module cpuif_ack_watchdog
    import cpuif_wdog_pkg::*;
#(
    parameter int ADDR_WIDTH     = c_cpuif_min_addr_w,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                     hclk_i,
    input  logic                     hreset_i,
    cpuif_ack_watchdog_if.slave      s_cpuif,
    cpuif_ack_watchdog_if.master     m_cpuif,
    output logic                     timeout_evt_o,
    output logic [TIMEOUT_CNT_W-1:0] timeout_cnt_o,
    input  logic                     timeout_cnt_clr_i
);

    localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT_CYCLES);

    cpuif_wdog_state_e     r_state;
    cpuif_wdog_state_e     w_state_nxt;
    logic                  r_is_wr;
    logic                  w_is_wr_nxt;
    logic                  r_from_wait;
    logic                  w_from_wait_nxt;

    logic [CNT_WIDTH-1:0]  r_wait_cnt;
    logic                  w_cnt_clr;
    logic                  w_cnt_restart;
    logic                  w_cnt_inc;
    logic                  w_cnt_done;

    logic                  w_req_stall;
    logic                  w_req_ack;
    logic                  w_lat_ack;
    logic                  w_fwd;
    logic                  w_fwd_wr;

    logic                  w_m_req;
    logic                  w_stall_wr;
    logic                  w_stall_rd;
    logic                  w_rd_ack;
    logic                  w_rd_err;
    logic                  w_wr_ack;
    logic                  w_wr_err;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_evt;

    // Request payload always follows upstream; only req itself is gated.
    assign w_addr            = s_cpuif.addr;
    assign m_cpuif.addr      = w_addr;
    assign m_cpuif.req_is_wr = s_cpuif.req_is_wr;
    assign m_cpuif.wr_data   = s_cpuif.wr_data;
    assign m_cpuif.wr_biten  = s_cpuif.wr_biten;

    assign w_req_stall = dir_sel(s_cpuif.req_is_wr, m_cpuif.req_stall_wr, m_cpuif.req_stall_rd);
    assign w_req_ack   = dir_sel(s_cpuif.req_is_wr, m_cpuif.wr_ack, m_cpuif.rd_ack);
    assign w_lat_ack   = dir_sel(r_is_wr, m_cpuif.wr_ack, m_cpuif.rd_ack);
    assign w_cnt_done  = (r_wait_cnt >= c_timeout);

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            r_state     <= IDLE;
            r_is_wr     <= 1'b0;
            r_from_wait <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_from_wait <= w_from_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_is_wr_nxt     = r_is_wr;
        w_from_wait_nxt = r_from_wait;
        w_cnt_clr       = 1'b0;
        w_cnt_restart   = 1'b0;
        w_cnt_inc       = 1'b0;
        w_fwd           = 1'b0;
        w_fwd_wr        = 1'b0;
        w_m_req         = 1'b0;
        w_stall_wr      = 1'b0;
        w_stall_rd      = 1'b0;
        w_rd_ack        = 1'b0;
        w_rd_err        = 1'b0;
        w_wr_ack        = 1'b0;
        w_wr_err        = 1'b0;
        w_rd_data       = '0;
        w_evt           = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_m_req    = s_cpuif.req;
                w_stall_wr = m_cpuif.req_stall_wr;
                w_stall_rd = m_cpuif.req_stall_rd;
                if (!s_cpuif.req) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_is_wr_nxt = s_cpuif.req_is_wr;
                    if (w_req_stall) begin
                        if (w_cnt_done) begin
                            w_state_nxt     = ERR_RESP;
                            w_from_wait_nxt = 1'b0;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end else if (w_req_ack) begin
                        w_fwd     = 1'b1;
                        w_fwd_wr  = s_cpuif.req_is_wr;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_restart = 1'b1;
                        w_state_nxt   = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                w_stall_wr = 1'b1;
                w_stall_rd = 1'b1;
                // An ack landing on the deadline cycle still wins over the error.
                if (w_lat_ack) begin
                    w_fwd       = 1'b1;
                    w_fwd_wr    = r_is_wr;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_cnt_done) begin
                    w_state_nxt     = ERR_RESP;
                    w_from_wait_nxt = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ERR_RESP: begin
                w_wr_ack    = r_is_wr;
                w_wr_err    = r_is_wr;
                w_rd_ack    = !r_is_wr;
                w_rd_err    = !r_is_wr;
                w_evt       = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = r_from_wait ? DRAIN : IDLE;
            end
            DRAIN: begin
                // The CSR block may still owe us an ack; absorb it silently.
                w_stall_wr = 1'b1;
                w_stall_rd = 1'b1;
                if (w_lat_ack || w_cnt_done) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_fwd) begin
            if (w_fwd_wr) begin
                w_wr_ack = 1'b1;
                w_wr_err = m_cpuif.wr_err;
            end else begin
                w_rd_ack  = 1'b1;
                w_rd_err  = m_cpuif.rd_err;
                w_rd_data = m_cpuif.rd_data;
            end
        end

        if (hreset_i) begin
            w_m_req    = 1'b0;
            w_stall_wr = 1'b0;
            w_stall_rd = 1'b0;
            w_rd_ack   = 1'b0;
            w_rd_err   = 1'b0;
            w_wr_ack   = 1'b0;
            w_wr_err   = 1'b0;
            w_rd_data  = '0;
            w_evt      = 1'b0;
        end
    end

    assign m_cpuif.req          = w_m_req;
    assign s_cpuif.req_stall_wr = w_stall_wr;
    assign s_cpuif.req_stall_rd = w_stall_rd;
    assign s_cpuif.rd_ack       = w_rd_ack;
    assign s_cpuif.rd_err       = w_rd_err;
    assign s_cpuif.rd_data      = w_rd_data;
    assign s_cpuif.wr_ack       = w_wr_ack;
    assign s_cpuif.wr_err       = w_wr_err;
    assign timeout_evt_o        = w_evt;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_wait_cnt (
        .clk       (hclk_i),
        .rst       (hreset_i),
        .i_clr     (w_cnt_clr),
        .i_restart (w_cnt_restart),
        .i_inc     (w_cnt_inc),
        .o_count   (r_wait_cnt)
    );

    sat_counter #(
        .WIDTH (TIMEOUT_CNT_W)
    ) u_timeout_cnt (
        .clk       (hclk_i),
        .rst       (hreset_i),
        .i_clr     (timeout_cnt_clr_i),
        .i_restart (1'b0),
        .i_inc     (w_evt),
        .o_count   (timeout_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpuif_ack_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpuif_ack_watchdog
// Brief    : Scoreboard bench for the CSR ack watchdog (255- and 2-cycle builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpuif_ack_watchdog;
    import cpuif_wdog_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    cpuif_ack_watchdog_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
    cpuif_ack_watchdog_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();
    cpuif_ack_watchdog_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fs_if ();
    cpuif_ack_watchdog_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fm_if ();

    logic                     evt, clr, evt_f, clr_f;
    logic [TIMEOUT_CNT_W-1:0] tcnt, tcnt_f;

    cpuif_ack_watchdog #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(255)) u_dut (
        .hclk_i(clk), .hreset_i(rst), .s_cpuif(s_if), .m_cpuif(m_if),
        .timeout_evt_o(evt), .timeout_cnt_o(tcnt), .timeout_cnt_clr_i(clr));

    cpuif_ack_watchdog #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(2)) u_dut_fast (
        .hclk_i(clk), .hreset_i(rst), .s_cpuif(fs_if), .m_cpuif(fm_if),
        .timeout_evt_o(evt_f), .timeout_cnt_o(tcnt_f), .timeout_cnt_clr_i(clr_f));

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   evt_seen   = 0;
    int   evt_f_seen = 0;
    logic [31:0] c0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic wr, input logic err, input logic [31:0] data, input logic [31:0] at);
        exp_q.push_back('{wr: wr, err: err, data: data, cyc: at});
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input logic [31:0] t);
        while (cyc < t) tick();
    endtask

    task automatic drive_idle();
        s_if.req = 0; s_if.req_is_wr = 0; s_if.addr = '0; s_if.wr_data = '0; s_if.wr_biten = '0;
        m_if.req_stall_wr = 0; m_if.req_stall_rd = 0; m_if.rd_ack = 0; m_if.rd_err = 0;
        m_if.rd_data = '0; m_if.wr_ack = 0; m_if.wr_err = 0;
        fs_if.req = 0; fs_if.req_is_wr = 0; fs_if.addr = '0; fs_if.wr_data = '0; fs_if.wr_biten = '0;
        fm_if.req_stall_wr = 0; fm_if.req_stall_rd = 0; fm_if.rd_ack = 0; fm_if.rd_err = 0;
        fm_if.rd_data = '0; fm_if.wr_ack = 0; fm_if.wr_err = 0;
    endtask

    // Monitor: every upstream ack must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (evt === 1'b1)   evt_seen++;
            if (evt_f === 1'b1) evt_f_seen++;
            chk("resp_quiet", {s_if.rd_err & ~s_if.rd_ack, s_if.wr_err & ~s_if.wr_ack,
                               (~s_if.rd_ack) & (s_if.rd_data != '0), s_if.rd_ack & s_if.wr_ack}, '0);
            if (s_if.rd_ack === 1'b1 || s_if.wr_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: actual wr_ack=%b rd_ack=%b at cycle %0d, required none",
                             s_if.wr_ack, s_if.rd_ack, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack", {s_if.wr_ack, s_if.rd_ack, s_if.wr_err, s_if.rd_err, s_if.rd_data, cyc},
                        {mon_e.wr, ~mon_e.wr, mon_e.wr & mon_e.err, ~mon_e.wr & mon_e.err, mon_e.data, mon_e.cyc});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; clr_f = 1'b0;
        drive_idle();
        s_if.req = 1; m_if.req_stall_rd = 1;
        tick(3);
        @(negedge clk);
        chk("rst_m_req", m_if.req, 0);
        chk("rst_stalls", {s_if.req_stall_wr, s_if.req_stall_rd}, 0);
        chk("rst_evt_cnt", {evt, tcnt}, 0);
        tick();
        rst = 1'b0;
        drive_idle();
        tick();

        // Read acked in the request cycle.
        c0 = cyc;
        s_if.req = 1; s_if.addr = 8'h10; m_if.rd_ack = 1; m_if.rd_data = 32'hDEADBEEF;
        push(0, 0, 32'hDEADBEEF, c0);
        @(negedge clk);
        chk("t1_m_req", {m_if.req, m_if.addr}, {1'b1, 8'h10});
        tick();
        drive_idle();
        m_if.req_stall_wr = 1;
        @(negedge clk);
        chk("t1_still_idle", {s_if.req_stall_wr, s_if.req_stall_rd}, 2'b10);
        tick();
        drive_idle();
        tick();

        // Write acked 10 cycles after acceptance; a stray read ack is ignored.
        c0 = cyc;
        s_if.req = 1; s_if.req_is_wr = 1; s_if.wr_data = 32'h0BADF00D; s_if.wr_biten = '1;
        push(1, 0, 32'h0, c0 + 10);
        @(negedge clk);
        chk("t2_wr_data", {m_if.req, m_if.req_is_wr, m_if.wr_data}, {2'b11, 32'h0BADF00D});
        wait_to(c0 + 3); m_if.rd_ack = 1; m_if.rd_data = 32'h55;
        tick(); m_if.rd_ack = 0; m_if.rd_data = '0;
        wait_to(c0 + 5);
        @(negedge clk);
        chk("t2_wait_gating", {m_if.req, s_if.req_stall_wr, s_if.req_stall_rd}, 3'b011);
        wait_to(c0 + 10); m_if.wr_ack = 1;
        tick(); drive_idle();
        tick();
        chk("t2_no_evt", evt_seen, 0);

        // Ack on the exact deadline cycle wins over the timeout.
        c0 = cyc;
        s_if.req = 1; s_if.req_is_wr = 1;
        push(1, 0, 32'h0, c0 + 255);
        wait_to(c0 + 255); m_if.wr_ack = 1;
        tick(); drive_idle();
        tick(2);
        chk("t2b_ack_wins", {evt_seen[7:0], tcnt}, 16'h0);

        // Read never acked: error ack at +256, late ack swallowed in drain.
        c0 = cyc;
        s_if.req = 1; s_if.addr = 8'h3C; m_if.rd_data = 32'h12345678;
        push(0, 1, 32'h0, c0 + 256);
        wait_to(c0 + 256);
        @(negedge clk);
        chk("t3_err_cycle", {evt, m_if.req}, 2'b10);
        tick(); s_if.req = 0;
        @(negedge clk);
        chk("t3_tcnt_drain", {tcnt, s_if.req_stall_rd}, {8'd1, 1'b1});
        wait_to(c0 + 300); m_if.rd_ack = 1;
        tick(); m_if.rd_ack = 0;
        @(negedge clk);
        chk("t3_back_idle", {s_if.req_stall_wr, s_if.req_stall_rd}, 2'b00);
        tick();
        s_if.req = 1; m_if.rd_ack = 1; m_if.rd_data = 32'hA5A55A5A;
        push(0, 0, 32'hA5A55A5A, cyc);
        tick(); drive_idle();
        tick();
        chk("t3_one_evt", evt_seen, 1);

        // Write stalled downstream for 300 cycles with req held.
        c0 = cyc;
        s_if.req = 1; s_if.req_is_wr = 1; m_if.req_stall_wr = 1;
        push(1, 1, 32'h0, c0 + 256);
        wait_to(c0 + 100);
        @(negedge clk);
        chk("t4_stall_pass", {s_if.req_stall_wr, s_if.req_stall_rd}, 2'b10);
        wait_to(c0 + 255);
        @(negedge clk);
        chk("t4_req_before", {m_if.req, evt}, 2'b10);
        wait_to(c0 + 256);
        @(negedge clk);
        chk("t4_req_in_err", {m_if.req, evt}, 2'b01);
        wait_to(c0 + 257);
        @(negedge clk);
        chk("t4_tcnt", tcnt, 2);
        wait_to(c0 + 300); drive_idle();
        tick();
        chk("t4_single_err", evt_seen, 2);

        // Fast build: first timeout three stalled cycles in, then saturation.
        c0 = cyc;
        fs_if.req = 1; fm_if.req_stall_rd = 1;
        wait_to(c0 + 2);
        @(negedge clk);
        chk("t5_before_first", evt_f, 0);
        wait_to(c0 + 3);
        @(negedge clk);
        chk("t5_first_timeout", {evt_f, fs_if.rd_ack, fs_if.rd_err}, 3'b111);
        wait_to(c0 + 1024);
        drive_idle();
        @(negedge clk);
        chk("t5_saturate", {evt_f_seen[15:0], tcnt_f}, {16'd256, 8'd255});
        tick();
        c0 = cyc;
        fs_if.req = 1; fm_if.req_stall_rd = 1;
        wait_to(c0 + 3); clr_f = 1;
        @(negedge clk);
        chk("t5_evt_with_clr", {evt_f, tcnt_f}, {1'b1, 8'd255});
        tick(); clr_f = 0; drive_idle();
        @(negedge clk);
        chk("t5_clr_wins", tcnt_f, 0);
        tick();

        // Reset in the fifth wait cycle: no error, everything back to zero.
        c0 = cyc;
        s_if.req = 1;
        wait_to(c0 + 4);
        @(negedge clk);
        chk("t6_pre_reset", {s_if.req_stall_rd, tcnt}, {1'b1, 8'd2});
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("t6_reset_gate", {s_if.req_stall_wr, s_if.req_stall_rd, m_if.req}, 3'b000);
        tick(); rst = 1'b0; s_if.req = 0;
        @(negedge clk);
        chk("t6_after_reset", {s_if.req_stall_rd, tcnt, tcnt_f}, 17'h0);
        wait_to(c0 + 8); m_if.rd_ack = 1; m_if.rd_data = 32'hFEEDFACE;
        tick(); drive_idle();
        wait_to(c0 + 280);
        chk("t6_no_error", {evt_seen[7:0], tcnt}, {8'd2, 8'd0});

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
